// File: rtl/sb_param_ccff_shadow.sv
// Corner-tile switch block (top + left sides): per-track routing muxes whose selectors are
// loaded serially into a shadow chain and made live only by a validated commit.
module sb_param_ccff_shadow #(
   parameter int CHAN_WIDTH = 9,
   parameter int GRID_PINS  = 1,
   parameter int OUT_REG    = 0
) (
   input  logic                            prog_clk,
   input  logic                            pReset,
   input  logic [CHAN_WIDTH-1:0]           chany_top_in,
   input  logic [CHAN_WIDTH-1:0]           chanx_left_in,
   input  logic [CHAN_WIDTH*GRID_PINS-1:0] top_grid_pin,
   input  logic [CHAN_WIDTH*GRID_PINS-1:0] left_grid_pin,
   input  logic                            ccff_head,
   input  logic                            ccff_en,
   input  logic                            ccff_commit,
   output logic [CHAN_WIDTH-1:0]           chany_top_out,
   output logic [CHAN_WIDTH-1:0]           chanx_left_out,
   output logic                            ccff_tail,
   output logic                            ccff_count_ok,
   output logic                            cfg_err
);

   localparam int SEL_W    = $clog2(GRID_PINS + 1);
   localparam int CFG_BITS = 2 * CHAN_WIDTH * SEL_W;
   localparam int CNT_W    = $clog2(CFG_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CFG_BITS + 1);

   logic [CFG_BITS-1:0]   sr;
   logic [CFG_BITS-1:0]   active;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nxt;
   logic [SEL_W-1:0]      sel [2*CHAN_WIDTH];
   logic [CHAN_WIDTH-1:0] top_d;
   logic [CHAN_WIDTH-1:0] left_d;

   // Commit decision uses the pre-shift count; a same-cycle shift restarts the count at 1.
   always_comb begin
      count_nxt = count;
      if (ccff_commit)
         count_nxt = ccff_en ? CNT_W'(1) : '0;
      else if (ccff_en)
         count_nxt = (count == CNT_SAT) ? count : count + 1'b1;
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         sr            <= '0;
         active        <= '0;
         count         <= '0;
         ccff_count_ok <= 1'b0;
         cfg_err       <= 1'b0;
      end else begin
         if (ccff_en)
            sr <= {sr[CFG_BITS-2:0], ccff_head};
         if (ccff_commit) begin
            if (count == CNT_N)
               active <= sr;
            else
               cfg_err <= 1'b1;
         end
         count         <= count_nxt;
         ccff_count_ok <= (count_nxt == CNT_N);
      end
   end

   assign ccff_tail = sr[CFG_BITS-1];

   // Lower chain index of each field is the selector MSB.
   always_comb begin
      for (int unsigned m = 0; m < 2*CHAN_WIDTH; m++) begin
         sel[m] = '0;
         for (int unsigned b = 0; b < SEL_W; b++)
            sel[m][SEL_W-1-b] = active[m*SEL_W + b];
      end
   end

   always_comb begin
      top_d  = '0;
      left_d = '0;
      for (int unsigned i = 0; i < CHAN_WIDTH; i++) begin
         int unsigned j;
         int unsigned st;
         int unsigned sl;
         j  = (i == 0) ? 0 : CHAN_WIDTH - i;
         st = 32'(sel[i]);
         sl = 32'(sel[CHAN_WIDTH + i]);
         if (st == 0)
            top_d[i] = chanx_left_in[j];
         else if (st <= GRID_PINS)
            top_d[i] = top_grid_pin[i*GRID_PINS + st - 1];
         if (sl == 0)
            left_d[i] = chany_top_in[j];
         else if (sl <= GRID_PINS)
            left_d[i] = left_grid_pin[i*GRID_PINS + sl - 1];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         always_ff @(posedge prog_clk) begin
            if (pReset) begin
               chany_top_out  <= '0;
               chanx_left_out <= '0;
            end else begin
               chany_top_out  <= top_d;
               chanx_left_out <= left_d;
            end
         end
      end else begin : g_out_comb
         assign chany_top_out  = top_d;
         assign chanx_left_out = left_d;
      end
   endgenerate

endmodule

// File: tb/tb_sb_param_ccff_shadow.sv
module tb_sb_param_ccff_shadow;

  logic       prog_clk = 1'b0;
  logic       pReset   = 1'b1;
  logic [8:0] chany_top_in  = '0;
  logic [8:0] chanx_left_in = '0;
  logic [8:0] top_grid_pin  = '0;
  logic [8:0] left_grid_pin = '0;
  logic       ccff_head = 1'b0, ccff_en = 1'b0, ccff_commit = 1'b0;

  logic [8:0] top_c, left_c, top_r, left_r;
  logic       tail_c, ok_c, err_c, tail_r, ok_r, err_r;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    int         sig;
    logic [8:0] exp;
  } exp_t;
  exp_t q[$];

  localparam int S_TOP = 0, S_LEFT = 1, S_TAIL = 2, S_OK = 3, S_ERR = 4, S_TOPR = 5, S_LEFTR = 6;

  always #5 prog_clk = ~prog_clk;

  sb_param_ccff_shadow #(.CHAN_WIDTH(9), .GRID_PINS(1), .OUT_REG(0)) u_comb (
    .prog_clk(prog_clk), .pReset(pReset), .chany_top_in(chany_top_in), .chanx_left_in(chanx_left_in),
    .top_grid_pin(top_grid_pin), .left_grid_pin(left_grid_pin), .ccff_head(ccff_head),
    .ccff_en(ccff_en), .ccff_commit(ccff_commit), .chany_top_out(top_c), .chanx_left_out(left_c),
    .ccff_tail(tail_c), .ccff_count_ok(ok_c), .cfg_err(err_c));

  sb_param_ccff_shadow #(.CHAN_WIDTH(9), .GRID_PINS(1), .OUT_REG(1)) u_reg (
    .prog_clk(prog_clk), .pReset(pReset), .chany_top_in(chany_top_in), .chanx_left_in(chanx_left_in),
    .top_grid_pin(top_grid_pin), .left_grid_pin(left_grid_pin), .ccff_head(ccff_head),
    .ccff_en(ccff_en), .ccff_commit(ccff_commit), .chany_top_out(top_r), .chanx_left_out(left_r),
    .ccff_tail(tail_r), .ccff_count_ok(ok_r), .cfg_err(err_r));

  function automatic logic [8:0] actual(int sig);
    case (sig)
      S_TOP:   return top_c;
      S_LEFT:  return left_c;
      S_TAIL:  return {8'd0, tail_c};
      S_OK:    return {8'd0, ok_c};
      S_ERR:   return {8'd0, err_c};
      S_TOPR:  return top_r;
      default: return left_r;
    endcase
  endfunction

  always @(negedge prog_clk) begin
    while (q.size() > 0) begin
      exp_t       e;
      logic [8:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      checks++;
      if (a !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sig, input logic [8:0] exp);
    q.push_back('{name, sig, exp});
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift(input logic b);
    ccff_head = b;
    ccff_en   = 1'b1;
    tick();
    ccff_en   = 1'b0;
  endtask

  task automatic do_commit();
    ccff_commit = 1'b1;
    tick();
    ccff_commit = 1'b0;
  endtask

  task automatic do_reset();
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    expect_val("rst_ok", S_OK, 9'h0);
    expect_val("rst_err", S_ERR, 9'h0);
    expect_val("rst_tail", S_TAIL, 9'h0);
    expect_val("rst_top_r", S_TOPR, 9'h0);
    expect_val("rst_left_r", S_LEFTR, 9'h0);
    chanx_left_in = 9'h101;
    expect_val("pass_top", S_TOP, 9'h003);
    expect_val("pass_left", S_LEFT, 9'h000);
    expect_val("pass_top_r_lag", S_TOPR, 9'h000);
    tick();
    expect_val("pass_top_r", S_TOPR, 9'h003);
    chany_top_in = 9'h0F0;
    expect_val("pass_left_twist", S_LEFT, 9'h03C);
    tick();
    expect_val("pass_left_r", S_LEFTR, 9'h03C);
    chany_top_in = 9'h000;

    top_grid_pin  = 9'h0AA;
    left_grid_pin = 9'h155;
    repeat (17) shift(1'b1);
    expect_val("ok_at_17", S_OK, 9'h0);
    shift(1'b1);
    expect_val("ok_at_18", S_OK, 9'h1);
    expect_val("tail_ones", S_TAIL, 9'h1);
    do_commit();
    expect_val("commit_top", S_TOP, 9'h0AA);
    expect_val("commit_left", S_LEFT, 9'h155);
    expect_val("commit_ok_clr", S_OK, 9'h0);
    expect_val("commit_err", S_ERR, 9'h0);
    expect_val("commit_top_r_lag", S_TOPR, 9'h003);
    tick();
    expect_val("commit_top_r", S_TOPR, 9'h0AA);
    expect_val("commit_left_r", S_LEFTR, 9'h155);

    do_reset();
    expect_val("rst2_top", S_TOP, 9'h003);
    expect_val("rst2_err", S_ERR, 9'h0);
    repeat (17) shift(1'b1);
    do_commit();
    expect_val("short_top", S_TOP, 9'h003);
    expect_val("short_err", S_ERR, 9'h1);
    repeat (18) shift(1'b1);
    do_commit();
    expect_val("valid_after_err_top", S_TOP, 9'h0AA);
    expect_val("err_sticky", S_ERR, 9'h1);
    do_reset();
    expect_val("err_cleared", S_ERR, 9'h0);
    expect_val("rst3_top", S_TOP, 9'h003);

    shift(1'b1);
    repeat (9) shift(1'b0);
    repeat (3) tick();
    expect_val("gap_ok", S_OK, 9'h0);
    expect_val("gap_tail", S_TAIL, 9'h0);
    repeat (7) shift(1'b0);
    expect_val("tail_at_17", S_TAIL, 9'h0);
    shift(1'b0);
    expect_val("tail_at_18", S_TAIL, 9'h1);
    expect_val("gap_ok_18", S_OK, 9'h1);

    ccff_head   = 1'b1;
    ccff_en     = 1'b1;
    ccff_commit = 1'b1;
    tick();
    ccff_en     = 1'b0;
    ccff_commit = 1'b0;
    expect_val("cs_top", S_TOP, 9'h003);
    expect_val("cs_left", S_LEFT, 9'h100);
    expect_val("cs_err", S_ERR, 9'h0);
    expect_val("cs_ok", S_OK, 9'h0);
    expect_val("cs_tail", S_TAIL, 9'h0);
    repeat (16) shift(1'b0);
    expect_val("cs_ok_17", S_OK, 9'h0);
    shift(1'b0);
    expect_val("cs_ok_18", S_OK, 9'h1);
    expect_val("cs_tail_18", S_TAIL, 9'h1);

    shift(1'b0);
    expect_val("ok_at_19", S_OK, 9'h0);
    shift(1'b0);
    expect_val("ok_sat", S_OK, 9'h0);
    do_commit();
    expect_val("long_err", S_ERR, 9'h1);
    expect_val("long_top", S_TOP, 9'h003);
    expect_val("long_left", S_LEFT, 9'h100);

    repeat (5) shift(1'b1);
    do_reset();
    expect_val("mid_rst_top", S_TOP, 9'h003);
    expect_val("mid_rst_left", S_LEFT, 9'h000);
    expect_val("mid_rst_tail", S_TAIL, 9'h0);
    expect_val("mid_rst_ok", S_OK, 9'h0);
    expect_val("mid_rst_err", S_ERR, 9'h0);
    expect_val("mid_rst_top_r", S_TOPR, 9'h000);
    expect_val("mid_rst_left_r", S_LEFTR, 9'h000);
    tick();
    expect_val("mid_rst_top_r_next", S_TOPR, 9'h003);
    repeat (17) shift(1'b1);
    expect_val("reload_ok_17", S_OK, 9'h0);
    shift(1'b1);
    expect_val("reload_ok_18", S_OK, 9'h1);

    @(negedge prog_clk);
    #1;
    checks++;
    if (ok_c !== 1'b1) begin
      failures++;
      $display("FAIL final_ok_c: got %b expected 1", ok_c);
    end
    checks++;
    if (ok_r !== 1'b1) begin
      failures++;
      $display("FAIL final_ok_r: got %b expected 1", ok_r);
    end
    checks++;
    if (tail_c !== 1'b1) begin
      failures++;
      $display("FAIL final_tail_c: got %b expected 1", tail_c);
    end
    checks++;
    if (tail_r !== 1'b1) begin
      failures++;
      $display("FAIL final_tail_r: got %b expected 1", tail_r);
    end
    checks++;
    if (err_c !== 1'b0) begin
      failures++;
      $display("FAIL final_err_c: got %b expected 0", err_c);
    end
    checks++;
    if (err_r !== 1'b0) begin
      failures++;
      $display("FAIL final_err_r: got %b expected 0", err_r);
    end
    checks++;
    if (top_c !== 9'h003) begin
      failures++;
      $display("FAIL final_top_c: got %h expected 003", top_c);
    end
    checks++;
    if (top_r !== 9'h003) begin
      failures++;
      $display("FAIL final_top_r: got %h expected 003", top_r);
    end
    checks++;
    if (left_c !== 9'h000) begin
      failures++;
      $display("FAIL final_left_c: got %h expected 000", left_c);
    end
    checks++;
    if (left_r !== 9'h000) begin
      failures++;
      $display("FAIL final_left_r: got %h expected 000", left_r);
    end
    checks++;
    if (top_r !== top_c) begin
      failures++;
      $display("FAIL final_top_match: reg %h comb %h", top_r, top_c);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
